// File: rtl/rpn_stack_ctrl.sv
// RPN token controller: sequences push/pop strobes to an external LIFO stack
// and evaluates two-operand operators (add, sub, and, or) on popped values.
module rpn_stack_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int STACK_SIZE = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            token_valid,
   input  logic                            token_is_op,
   input  logic [1:0]                      token_op,
   input  logic [DATA_WIDTH-1:0]           token_data,
   output logic                            token_ready,
   output logic                            stk_push,
   output logic                            stk_pop,
   output logic [DATA_WIDTH-1:0]           stk_write_data,
   input  logic [DATA_WIDTH-1:0]           stk_read_data,
   output logic [DATA_WIDTH-1:0]           result,
   output logic                            result_valid,
   output logic                            error,
   output logic [$clog2(STACK_SIZE+1)-1:0] depth
);

   localparam int DEPTH_W = $clog2(STACK_SIZE + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POP_B,
      POP_A,
      CALC
   } state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0] write_data_q;
   logic [DATA_WIDTH-1:0] operand_b_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [DATA_WIDTH-1:0] calc_value;
   logic [DEPTH_W-1:0]    depth_q;
   logic [1:0]            op_q;
   logic                  from_op_q;
   logic                  error_q;
   logic                  accept_num;
   logic                  accept_op;
   logic                  reject;

   always_comb begin
      next_state  = state;
      token_ready = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      accept_num  = 1'b0;
      accept_op   = 1'b0;
      reject      = 1'b0;
      case (state)
         IDLE: begin
            token_ready = 1'b1;
            if (token_valid) begin
               if (token_is_op) begin
                  if (depth_q >= DEPTH_TWO) begin
                     accept_op  = 1'b1;
                     next_state = POP_B;
                  end else begin
                     reject = 1'b1;
                  end
               end else begin
                  if (depth_q < DEPTH_FULL) begin
                     accept_num = 1'b1;
                     next_state = PUSH;
                  end else begin
                     reject = 1'b1;
                  end
               end
            end
         end
         PUSH: begin
            stk_push   = 1'b1;
            next_state = IDLE;
         end
         POP_B: begin
            stk_pop    = 1'b1;
            next_state = POP_A;
         end
         POP_A: begin
            stk_pop    = 1'b1;
            next_state = CALC;
         end
         CALC: begin
            next_state = PUSH;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // In CALC the stack's registered read port presents operand A (second pop).
   always_comb begin
      calc_value = '0;
      case (op_q)
         2'b00:   calc_value = stk_read_data + operand_b_q;
         2'b01:   calc_value = stk_read_data - operand_b_q;
         2'b10:   calc_value = stk_read_data & operand_b_q;
         default: calc_value = stk_read_data | operand_b_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         write_data_q <= '0;
         operand_b_q  <= '0;
         result_q     <= '0;
         depth_q      <= '0;
         op_q         <= '0;
         from_op_q    <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state   <= next_state;
         error_q <= reject;
         if (accept_num) begin
            write_data_q <= token_data;
            from_op_q    <= 1'b0;
         end
         if (accept_op) begin
            op_q      <= token_op;
            from_op_q <= 1'b1;
         end
         if (state == POP_A) begin
            operand_b_q <= stk_read_data;
         end
         if (state == CALC) begin
            result_q     <= calc_value;
            write_data_q <= calc_value;
         end
         if (stk_push && depth_q != DEPTH_FULL) begin
            depth_q <= depth_q + 1'b1;
         end else if (stk_pop && depth_q != '0) begin
            depth_q <= depth_q - 1'b1;
         end
      end
   end

   assign stk_write_data = write_data_q;
   assign result         = result_q;
   assign result_valid   = (state == PUSH) && from_op_q;
   assign error          = error_q;
   assign depth          = depth_q;

endmodule

// File: doc/rpn_stack_ctrl.md
RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter STACK_SIZE, default 4, entry capacity of the attached LIFO stack.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port token_valid  input  1  token offered this cycle.
REQ-006 SHALL have port token_is_op  input  1  1 = operator token, 0 = number token.
REQ-007 SHALL have port token_op  input  2  operator code: 00 add, 01 sub, 10 and, 11 or.
REQ-008 SHALL have port token_data  input  DATA_WIDTH  number value; ignored for operators.
REQ-009 SHALL have port token_ready  output  1  controller can accept a token.
REQ-010 SHALL have port stk_push  output  1  push strobe to the stack.
REQ-011 SHALL have port stk_pop  output  1  pop strobe to the stack.
REQ-012 SHALL have port stk_write_data  output  DATA_WIDTH  data pushed to the stack.
REQ-013 SHALL have port stk_read_data  input  DATA_WIDTH  popped value, valid the cycle after stk_pop.
REQ-014 SHALL have port result  output  DATA_WIDTH  last computed operator result.
REQ-015 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-016 SHALL have port error  output  1  one-cycle pulse on rejected token.
REQ-017 SHALL have port depth  output  $clog2(STACK_SIZE+1)  current stack occupancy.

Function
REQ-018 SHALL implement an FSM with states IDLE, PUSH, POP_B, POP_A, CALC.
REQ-019 SHALL drive token_ready=1 only in IDLE; a token is accepted when token_valid && token_ready at a rising edge.
REQ-020 Number accepted with depth<STACK_SIZE SHALL latch token_data, go to PUSH, and assert stk_push with stk_write_data=latched value for exactly one cycle (T+1).
REQ-021 Operator accepted with depth>=2 SHALL go POP_B (stk_pop=1, T+1), then POP_A (stk_pop=1, T+2, operand B captured from stk_read_data), then CALC (T+3, operand A taken from stk_read_data, result registered), then PUSH (T+4, stk_push=1, stk_write_data=result, result_valid=1), then IDLE (T+5).
REQ-022 Arithmetic SHALL be A op B, modulo 2^DATA_WIDTH; sub is A-B; overflow/borrow discarded silently.
REQ-023 depth SHALL increment on every stk_push cycle and decrement on every stk_pop cycle, never leaving range 0..STACK_SIZE.
REQ-024 Number accepted with depth==STACK_SIZE SHALL pulse error at T+1, issue no stk_push, leave depth unchanged, and remain in IDLE.
REQ-025 Operator accepted with depth<2 SHALL pulse error at T+1, issue no stk_pop/stk_push, leave depth and result unchanged.
REQ-026 stk_push and stk_pop SHALL never be asserted in the same cycle.
REQ-027 token_valid while token_ready=0 SHALL be ignored with no side effect; the source holds it until accepted.
REQ-028 stk_write_data SHALL hold its last value when stk_push is low.

Reset
REQ-029 Assertion of reset SHALL immediately, without waiting for a clock edge, force state IDLE, depth=0, result=0, stk_push=0, stk_pop=0, stk_write_data=0, result_valid=0, error=0.
REQ-030 Reset mid-sequence SHALL abandon the operation; partial operands are discarded. The same reset SHALL be routed to the stack so that its pointer matches depth=0.
REQ-031 token_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Push 3, push 4, op add -> stk_pop at T+1,T+2; result=7 with result_valid at T+4; depth=1.
REQ-033 Push 10, push 3, op sub -> result=7; push 3, push 10, op sub -> result=249 (8-bit wrap).
REQ-034 Push 200, push 100, op add -> result=44; op and on 0xF0,0x3C -> 0x30; op or -> 0xFC.
REQ-035 depth=1, op add -> error pulse at T+1, no stk_pop, depth stays 1, result unchanged.
REQ-036 Five number pushes with STACK_SIZE=4 -> fifth gives error, no stk_push, depth=4.
REQ-037 Assert reset during POP_A -> outputs zero before next edge, depth=0, token_ready=1 after release.
